neuron_sequencer: RTL and testbench

Time-multiplexing controller for the neuron pool datapath. It derives `neuron_clk` from `rawclk` and generates the `neuronCounter` phase/index sequence that the Izhikevich neuron and synapse RAM pipelines consume. It starts and stops the pool cleanly on frame boundaries. It optionally captures motoneuron spike events into a FIFO for host readout. It sits between the host configuration registers (`half_cnt`, `run`) and one or more neuron pools.

---
 rtl/neuron_seq_pkg.sv | 19 +
 rtl/spike_fifo.sv | 53 +++++
 rtl/neuron_sequencer.sv | 136 +++++++++++++
 tb/tb_neuron_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_seq_pkg.sv
// Shared types and constants for the neuron pool sequencer and its spike FIFO.
package neuron_seq_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRun      = 2'd1,
        StStopping = 2'd2
    } seq_state_e;

    // Pipeline phase held in neuronCounter[1:0]
    localparam logic [1:0] ST_INC  = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd3;

    function automatic int unsigned num_neuron(input int unsigned nn);
        return 32'd1 << (nn + 1);
    endfunction

endpackage

// File: rtl/spike_fifo.sv
// Synchronous show-ahead FIFO for motoneuron spike indices with a sticky overflow flag.
// DEPTH must be a power of two, at least 2.
module spike_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic             rawclk,
    input  logic             reset_sim,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_overflow
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             r_overflow;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = i_pop && !w_empty;
    // A pop frees the head slot on the same edge, so a push into a full FIFO still lands
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge rawclk or posedge reset_sim) begin
        if (reset_sim) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW + 1)'(1);
            if (w_pop) r_rptr <= r_rptr + (AW + 1)'(1);
            if (i_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge rawclk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_valid    = !w_empty;
    assign o_data     = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign o_overflow = r_overflow;

endmodule

// File: rtl/neuron_sequencer.sv
// Neuron pool time-multiplexing controller: neuron_clk divider, neuronCounter sequence,
// frame-aligned start/stop. Define SPIKE_CAPTURE_EN to capture spikes into spike_fifo.
module neuron_sequencer
    import neuron_seq_pkg::*;
#(
    parameter int unsigned NN         = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic          rawclk,
    input  logic          reset_sim,
    input  logic          run,
    input  logic [31:0]   half_cnt,
    output logic          neuron_clk,
    output logic [NN+2:0] neuronCounter,
    output logic          frame_start,
    output logic          running,
    input  logic          spike_in,
    output logic          spk_valid,
    input  logic          spk_ready,
    output logic [NN:0]   spk_index,
    output logic          spk_overflow
);
    localparam int unsigned NumNeuron = num_neuron(NN);
    localparam logic [NN:0] LastIdx   = (NN + 1)'(NumNeuron - 1);

    seq_state_e    r_state;
    seq_state_e    w_state_d;
    logic [31:0]   r_div_cnt;
    logic [31:0]   w_div_d;
    logic [31:0]   r_half_shadow;
    logic [31:0]   w_half_d;
    logic          r_nclk;
    logic          w_nclk_d;
    logic [NN+2:0] r_ncnt;
    logic [NN+2:0] w_ncnt_d;
    logic          r_frame_start;
    logic          w_frame_start_d;
    logic          w_toggle;
    logic          w_fall;
    logic          w_wrap;

    assign w_toggle = (r_div_cnt == r_half_shadow);
    assign w_fall   = (r_state != StIdle) && w_toggle && r_nclk;
    assign w_wrap   = w_fall && (r_ncnt[NN+2:2] == LastIdx) && (r_ncnt[1:0] == ST_WR);

    always_comb begin
        w_state_d       = r_state;
        w_div_d         = r_div_cnt;
        w_half_d        = r_half_shadow;
        w_nclk_d        = r_nclk;
        w_ncnt_d        = r_ncnt;
        w_frame_start_d = 1'b0;
        case (r_state)
            StIdle: begin
                w_div_d  = '0;
                w_nclk_d = 1'b0;
                w_ncnt_d = '0;
                w_half_d = half_cnt;
                if (run) begin
                    w_state_d       = StRun;
                    w_frame_start_d = 1'b1;
                end
            end
            default: begin
                if (w_toggle) begin
                    w_div_d  = '0;
                    w_nclk_d = !r_nclk;
                end else begin
                    w_div_d = r_div_cnt + 32'd1;
                end
                if (w_fall) w_ncnt_d = r_ncnt + (NN + 3)'(1);
                // Period changes only take effect at frame boundaries
                if (w_wrap) begin
                    w_frame_start_d = 1'b1;
                    w_half_d        = half_cnt;
                end
                if (w_wrap && !run) w_state_d = StIdle;
                else if (run)       w_state_d = StRun;
                else                w_state_d = StStopping;
            end
        endcase
    end

    always_ff @(posedge rawclk or posedge reset_sim) begin
        if (reset_sim) begin
            r_state       <= StIdle;
            r_div_cnt     <= '0;
            r_half_shadow <= '0;
            r_nclk        <= 1'b0;
            r_ncnt        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_div_cnt     <= w_div_d;
            r_half_shadow <= w_half_d;
            r_nclk        <= w_nclk_d;
            r_ncnt        <= w_ncnt_d;
            r_frame_start <= w_frame_start_d;
        end
    end

    assign neuron_clk    = r_nclk;
    assign neuronCounter = r_ncnt;
    assign frame_start   = r_frame_start;
    assign running       = (r_state != StIdle);

`ifdef SPIKE_CAPTURE_EN
    logic w_push;

    // Push the pre-increment index on the falling neuron_clk edge that closes the write phase
    assign w_push = w_fall && (r_ncnt[1:0] == ST_WR) && spike_in;

    spike_fifo #(
        .WIDTH (NN + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_spike_fifo (
        .rawclk     (rawclk),
        .reset_sim  (reset_sim),
        .i_push     (w_push),
        .i_data     (r_ncnt[NN+2:2]),
        .i_pop      (spk_ready),
        .o_valid    (spk_valid),
        .o_data     (spk_index),
        .o_overflow (spk_overflow)
    );
`else
    localparam int unsigned unused_fifo_depth = FIFO_DEPTH;
    logic w_unused_spk;

    assign w_unused_spk = spike_in ^ spk_ready;
    assign spk_valid    = 1'b0;
    assign spk_index    = '0;
    assign spk_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed self-checking bench for neuron_sequencer (NN=1, FIFO_DEPTH=4).
module tb_neuron_sequencer;
    localparam int unsigned NN = 1;

    logic        rawclk    = 1'b0;
    logic        reset_sim = 1'b1;
    logic        run       = 1'b0;
    logic [31:0] half_cnt  = 32'd2;
    logic        spike_in  = 1'b0;
    logic        spk_ready = 1'b0;
    logic        neuron_clk;
    logic [3:0]  neuronCounter;
    logic        frame_start;
    logic        running;
    logic        spk_valid;
    logic [1:0]  spk_index;
    logic        spk_overflow;

    int checks   = 0;
    int failures = 0;

    always #5 rawclk = ~rawclk;

    neuron_sequencer #(
        .NN         (NN),
        .FIFO_DEPTH (4)
    ) dut (
        .rawclk        (rawclk),
        .reset_sim     (reset_sim),
        .run           (run),
        .half_cnt      (half_cnt),
        .neuron_clk    (neuron_clk),
        .neuronCounter (neuronCounter),
        .frame_start   (frame_start),
        .running       (running),
        .spike_in      (spike_in),
        .spk_valid     (spk_valid),
        .spk_ready     (spk_ready),
        .spk_index     (spk_index),
        .spk_overflow  (spk_overflow)
    );

    // One rawclk cycle; inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(posedge rawclk);
        @(negedge rawclk);
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        reset_sim = 1'b1;
        repeat (3) @(negedge rawclk);
        obs = {neuron_clk, neuronCounter, frame_start, running, spk_valid, spk_index, spk_overflow};
        checks++;
        if (obs !== 11'd0) begin
            failures++;
            $display("FAIL reset_values got=%b exp=%b", obs, 11'd0);
        end
        reset_sim = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            obs = {neuron_clk, neuronCounter, frame_start, running, spk_valid, spk_index,
                   spk_overflow};
            checks++;
            if (obs !== 11'd0) begin
                failures++;
                $display("FAIL idle_hold cyc=%0d got=%b exp=%b", n, obs, 11'd0);
            end
        end
    endtask

    // half_cnt=2: 6-cycle neuron_clk, counter advances every 6 cycles, frame of 96 cycles
    task automatic test_run();
        logic [6:0] obs, exp;
        half_cnt = 32'd2;
        run      = 1'b1;
        for (int n = 0; n <= 100; n++) begin
            step();
            exp = {((n % 6) >= 3), 4'((n / 6) % 16), (n % 96 == 0), 1'b1};
            obs = {neuron_clk, neuronCounter, frame_start, running};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL run_seq cyc=%0d got=%b exp=%b", n, obs, exp);
            end
        end
    endtask

    // Period change mid-frame only applies after the wrap at cycle 192
    task automatic test_half_change();
        logic [6:0] obs, exp;
        half_cnt = 32'd0;
        for (int n = 101; n < 192; n++) begin
            step();
            exp = {((n % 6) >= 3), 4'((n / 6) % 16), (n % 96 == 0), 1'b1};
            obs = {neuron_clk, neuronCounter, frame_start, running};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL half_old cyc=%0d got=%b exp=%b", n, obs, exp);
            end
        end
        for (int m = 0; m < 64; m++) begin
            step();
            exp = {(m % 2 == 1), 4'((m / 2) % 16), (m % 32 == 0), 1'b1};
            obs = {neuron_clk, neuronCounter, frame_start, running};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL half_new m=%0d got=%b exp=%b", m, obs, exp);
            end
        end
    endtask

    // Drop run at counter 5; pool finishes the frame then idles
    task automatic test_stop();
        logic [6:0] obs, exp;
        for (int m = 64; m <= 74; m++) begin
            step();
            exp = {(m % 2 == 1), 4'((m / 2) % 16), (m % 32 == 0), 1'b1};
            obs = {neuron_clk, neuronCounter, frame_start, running};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL stop_pre m=%0d got=%b exp=%b", m, obs, exp);
            end
        end
        run = 1'b0;
        for (int r = 1; r <= 22; r++) begin
            step();
            exp = {((74 + r) % 2 == 1), 4'(((74 + r) / 2) % 16), (r == 22), (r < 22)};
            obs = {neuron_clk, neuronCounter, frame_start, running};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL stop_drain r=%0d got=%b exp=%b", r, obs, exp);
            end
        end
        for (int k = 0; k < 20; k++) begin
            step();
            obs = {neuron_clk, neuronCounter, frame_start, running};
            checks++;
            if (obs !== 7'd0) begin
                failures++;
                $display("FAIL stop_idle k=%0d got=%b exp=%b", k, obs, 7'd0);
            end
        end
    endtask

    // half_cnt=0 run, reset asserted asynchronously at counter 9
    task automatic test_reset_midframe();
        logic [6:0]  obs, exp;
        logic [10:0] all;
        run = 1'b1;
        for (int n = 0; n <= 18; n++) begin
            step();
            exp = {(n % 2 == 1), 4'(n / 2), (n == 0), 1'b1};
            obs = {neuron_clk, neuronCounter, frame_start, running};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL midframe_run cyc=%0d got=%b exp=%b", n, obs, exp);
            end
        end
        #2 reset_sim = 1'b1;
        #1;
        all = {neuron_clk, neuronCounter, frame_start, running, spk_valid, spk_index, spk_overflow};
        checks++;
        if (all !== 11'd0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", all, 11'd0);
        end
        run = 1'b0;
        @(negedge rawclk);
        reset_sim = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            obs = {neuron_clk, neuronCounter, frame_start, running};
            checks++;
            if (obs !== 7'd0) begin
                failures++;
                $display("FAIL post_reset_idle k=%0d got=%b exp=%b", k, obs, 7'd0);
            end
        end
    endtask

`ifdef SPIKE_CAPTURE_EN
    task automatic test_spike_order();
        int k;
        spk_ready = 1'b0;
        run       = 1'b1;
        for (int n = 0; n < 40; n++) begin
            step();
            spike_in = (neuronCounter[1:0] == 2'b11) &&
                       (neuronCounter[3:2] == 2'd2 || neuronCounter[3:2] == 2'd3);
        end
        spike_in = 1'b0;
        run      = 1'b0;
        checks++;
        if ({spk_valid, spk_index} !== 3'b110) begin
            failures++;
            $display("FAIL spike_head0 got=%b exp=%b", {spk_valid, spk_index}, 3'b110);
        end
        spk_ready = 1'b1;
        step();
        checks++;
        if ({spk_valid, spk_index} !== 3'b111) begin
            failures++;
            $display("FAIL spike_head1 got=%b exp=%b", {spk_valid, spk_index}, 3'b111);
        end
        step();
        checks++;
        if (spk_valid !== 1'b0) begin
            failures++;
            $display("FAIL spike_empty got=%b exp=0", spk_valid);
        end
        spk_ready = 1'b0;
        for (k = 0; k < 200 && running; k++) step();
        checks++;
        if (running !== 1'b0) begin
            failures++;
            $display("FAIL spike_stop_timeout running=%b exp=0", running);
        end
    endtask

    task automatic test_overflow();
        logic [2:0] exp;
        @(negedge rawclk);
        reset_sim = 1'b1;
        @(negedge rawclk);
        reset_sim = 1'b0;
        spk_ready = 1'b0;
        spike_in  = 1'b1;
        run       = 1'b1;
        for (int n = 0; n <= 40; n++) begin
            step();
            if (n == 32) begin
                checks++;
                if ({spk_valid, spk_overflow, spk_index} !== 4'b1000) begin
                    failures++;
                    $display("FAIL ovf_full got=%b exp=%b",
                             {spk_valid, spk_overflow, spk_index}, 4'b1000);
                end
            end
        end
        spike_in = 1'b0;
        run      = 1'b0;
        checks++;
        if (spk_overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag got=%b exp=1", spk_overflow);
        end
        spk_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, 2'(i)};
            checks++;
            if ({spk_valid, spk_index} !== exp) begin
                failures++;
                $display("FAIL ovf_pop%0d got=%b exp=%b", i, {spk_valid, spk_index}, exp);
            end
            step();
        end
        checks++;
        if ({spk_valid, spk_overflow} !== 2'b01) begin
            failures++;
            $display("FAIL ovf_drained got=%b exp=%b", {spk_valid, spk_overflow}, 2'b01);
        end
        spk_ready = 1'b0;
    endtask
`else
    task automatic test_spike_disabled();
        spike_in = 1'b1;
        run      = 1'b1;
        for (int n = 0; n < 40; n++) begin
            step();
            checks++;
            if ({spk_valid, spk_index, spk_overflow} !== 4'd0) begin
                failures++;
                $display("FAIL spike_tied cyc=%0d got=%b exp=%b", n,
                         {spk_valid, spk_index, spk_overflow}, 4'd0);
            end
        end
        spike_in = 1'b0;
        run      = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_run();
        test_half_change();
        test_stop();
        test_reset_midframe();
`ifdef SPIKE_CAPTURE_EN
        test_spike_order();
        test_overflow();
`else
        test_spike_disabled();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
